// File: rtl/dec_top.sv
// Extended-Hamming SEC-DED decoder for a 137-bit codeword (128 data, 8 check, 1 overall parity).
// Latency: one cycle, IN is sampled and all outputs are registered on the rising edge of clk.
// Backpressure: none; a new codeword is accepted every cycle and nothing ever stalls.
//
// Ports:
//   clk    rising-edge clock for the output registers
//   reset  synchronous active-high reset; clears every output register
//   IN     received codeword; IN[0] = overall parity, IN[1..136] = Hamming positions
//   OUT    corrected codeword (IN with one bit flipped when a single error is found)
//   SYN    {overall parity, Hamming syndrome}
//   ERR    any error seen; SGL single error corrected; DBL uncorrectable error seen
module dec_top (
    input  logic         clk,
    input  logic         reset,
    input  logic [136:0] IN,
    output logic [136:0] OUT,
    output logic [8:0]   SYN,
    output logic         ERR,
    output logic         SGL,
    output logic         DBL
);

    localparam logic [7:0] MAX_POS = 8'd136;

    logic [7:0]   ham_syn;
    logic         par;
    logic         sgl_d;
    logic         dbl_d;
    logic         err_d;
    logic [8:0]   syn_d;
    logic [136:0] flip;
    logic [136:0] out_d;

    logic [136:0] out_q;
    logic [8:0]   syn_q;
    logic         err_q;
    logic         sgl_q;
    logic         dbl_q;

    // Each set bit at position i contributes its index to the syndrome, so
    // XOR-accumulating the indices gives every syndrome bit in one pass.
    always_comb begin
        ham_syn = '0;
        for (int i = 1; i < 137; i++) begin
            if (IN[i]) begin
                ham_syn = ham_syn ^ 8'(i);
            end
        end
    end

    assign par = ^IN;

    // Odd overall parity means an odd number of flips; only a syndrome that
    // names a real position (0 = the parity bit itself) is treated as a single
    // correctable error. An out-of-range syndrome with odd parity cannot come
    // from one flip, so it is reported as uncorrectable.
    always_comb begin
        sgl_d = 1'b0;
        dbl_d = 1'b0;
        if (par) begin
            if (ham_syn <= MAX_POS) begin
                sgl_d = 1'b1;
            end else begin
                dbl_d = 1'b1;
            end
        end else if (ham_syn != 8'd0) begin
            dbl_d = 1'b1;
        end
    end

    assign err_d = sgl_d | dbl_d;
    assign syn_d = {par, ham_syn};

    // One-hot correction mask; all zero unless a single error was located.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 137; i++) begin
            flip[i] = sgl_d && (ham_syn == 8'(i));
        end
    end

    assign out_d = IN ^ flip;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            syn_q <= '0;
            err_q <= 1'b0;
            sgl_q <= 1'b0;
            dbl_q <= 1'b0;
        end else begin
            out_q <= out_d;
            syn_q <= syn_d;
            err_q <= err_d;
            sgl_q <= sgl_d;
            dbl_q <= dbl_d;
        end
    end

    assign OUT = out_q;
    assign SYN = syn_q;
    assign ERR = err_q;
    assign SGL = sgl_q;
    assign DBL = dbl_q;

endmodule

// File: tb/tb_dec_top.sv
// Self-checking bench for dec_top: directed scenarios plus random encoded codewords
// with injected errors, compared against a behavioural SEC-DED model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_dec_top;

    logic         clk;
    logic         reset;
    logic [136:0] IN;
    logic [136:0] OUT;
    logic [8:0]   SYN;
    logic         ERR;
    logic         SGL;
    logic         DBL;

    int total;
    int bad;

    // Expected values for the most recently clocked input.
    logic [136:0] e_out;
    logic [8:0]   e_syn;
    logic         e_err;
    logic         e_sgl;
    logic         e_dbl;

    dec_top dut (
        .clk   (clk),
        .reset (reset),
        .IN    (IN),
        .OUT   (OUT),
        .SYN   (SYN),
        .ERR   (ERR),
        .SGL   (SGL),
        .DBL   (DBL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Syndrome bit k is the parity of the count of set bits at positions whose
    // index has bit k set; bit 8 is the parity of the whole word.
    function automatic logic [8:0] model_syn(input logic [136:0] v);
        logic [8:0] s;
        int cnt;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            cnt = 0;
            for (int i = 1; i <= 136; i++) begin
                if (((i >> k) & 1) == 1 && v[i]) cnt++;
            end
            s[k] = (cnt % 2) == 1;
        end
        s[8] = ($countones(v) % 2) == 1;
        return s;
    endfunction

    // Build a valid codeword: data in non-power-of-two positions, then choose
    // each check bit to cancel its syndrome bit, then fix overall parity.
    function automatic logic [136:0] encode(input logic [127:0] data);
        logic [136:0] cw;
        logic [8:0]   s;
        int d;
        cw = '0;
        d = 0;
        for (int i = 1; i <= 136; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = data[d];
                d++;
            end
        end
        s = model_syn(cw);
        for (int k = 0; k < 8; k++) cw[1 << k] = s[k];
        cw[0] = ($countones(cw[136:1]) % 2) == 1;
        return cw;
    endfunction

    task automatic set_expect(input logic [136:0] v, input logic rst);
        int h;
        if (rst) begin
            e_out = '0; e_syn = '0; e_err = 0; e_sgl = 0; e_dbl = 0;
        end else begin
            e_syn = model_syn(v);
            h     = int'(e_syn[7:0]);
            e_out = v;
            e_sgl = 0;
            e_dbl = 0;
            if (e_syn[8] && h <= 136) begin
                e_sgl = 1;
                e_out[h] = ~v[h];
            end else if (e_syn != 9'd0) begin
                e_dbl = 1;
            end
            e_err = e_sgl | e_dbl;
        end
    endtask

    task automatic chk(input string tag, input logic [136:0] obs, input logic [136:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".OUT"}, OUT, e_out);
        chk({tag, ".SYN"}, 137'(SYN), 137'(e_syn));
        chk({tag, ".ERR"}, 137'(ERR), 137'(e_err));
        chk({tag, ".SGL"}, 137'(SGL), 137'(e_sgl));
        chk({tag, ".DBL"}, 137'(DBL), 137'(e_dbl));
    endtask

    // Drive one input (optionally with reset), confirm outputs have not moved
    // before the edge, then check the result one edge later.
    task automatic apply(input string tag, input logic [136:0] v, input logic rst);
        IN    = v;
        reset = rst;
        #1;
        chk({tag, ".hold_out"}, OUT, e_out);
        chk({tag, ".hold_syn"}, 137'(SYN), 137'(e_syn));
        @(posedge clk);
        #1;
        set_expect(v, rst);
        chk_all(tag);
    endtask

    initial begin
        logic [136:0] v;
        logic [136:0] cw;
        logic [127:0] data;
        int mode;
        int p;
        int q;

        total = 0;
        bad   = 0;
        IN    = '0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        set_expect('0, 1'b1);
        chk_all("reset");

        // All zero
        apply("zero", '0, 1'b0);
        chk("zero.syn_const", 137'(SYN), 137'(9'h000));

        // Parity bit only
        v = '0; v[0] = 1'b1;
        apply("bit0", v, 1'b0);
        chk("bit0.syn_const", 137'(SYN), 137'(9'h100));
        chk("bit0.out_const", OUT, '0);
        chk("bit0.sgl_const", 137'(SGL), 137'(1'b1));

        // Single errors at position 5 and at the top position 136
        v = '0; v[5] = 1'b1;
        apply("bit5", v, 1'b0);
        chk("bit5.syn_const", 137'(SYN), 137'(9'h105));
        chk("bit5.out_const", OUT, '0);
        v = '0; v[136] = 1'b1;
        apply("bit136", v, 1'b0);
        chk("bit136.syn_const", 137'(SYN), 137'(9'h188));
        chk("bit136.out_const", OUT, '0);
        chk("bit136.sgl_const", 137'(SGL), 137'(1'b1));

        // Double errors
        v = '0; v[3] = 1'b1; v[5] = 1'b1;
        apply("dbl35", v, 1'b0);
        chk("dbl35.syn_const", 137'(SYN), 137'(9'h006));
        chk("dbl35.dbl_const", 137'(DBL), 137'(1'b1));
        chk("dbl35.out_const", OUT, v);
        v = '0; v[135] = 1'b1; v[136] = 1'b1;
        apply("dbl135", v, 1'b0);
        chk("dbl135.syn_const", 137'(SYN), 137'(9'h00F));
        chk("dbl135.dbl_const", 137'(DBL), 137'(1'b1));

        // Odd parity but syndrome 145 points past the codeword
        v = '0; v[1] = 1'b1; v[16] = 1'b1; v[128] = 1'b1;
        apply("inv145", v, 1'b0);
        chk("inv145.syn_const", 137'(SYN), 137'(9'h191));
        chk("inv145.sgl_const", 137'(SGL), 137'(1'b0));
        chk("inv145.dbl_const", 137'(DBL), 137'(1'b1));
        chk("inv145.out_const", OUT, v);

        // Back-to-back stream with a one-cycle reset pulse in the middle
        for (int n = 0; n < 8; n++) begin
            v = {$urandom, $urandom, $urandom, $urandom, 9'($urandom)};
            apply("stream", v, n == 4);
            if (n == 4) begin
                chk("stream.rst_out", OUT, '0);
                chk("stream.rst_err", 137'(ERR), 137'(1'b0));
            end
        end

        // Random encoded codewords with 0, 1, 2 injected flips or raw noise
        for (int n = 0; n < 300; n++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            cw   = encode(data);
            mode = int'($urandom_range(0, 3));
            p    = int'($urandom_range(0, 136));
            q    = (p + 1 + int'($urandom_range(0, 135))) % 137;
            v    = cw;
            case (mode)
                0: ;
                1: v[p] = ~v[p];
                2: begin v[p] = ~v[p]; v[q] = ~v[q]; end
                default: v = {$urandom, $urandom, $urandom, $urandom, 9'($urandom)};
            endcase
            apply("rand", v, 1'b0);
            if (mode == 0) begin
                chk("rand.clean_err", 137'(ERR), 137'(1'b0));
                chk("rand.clean_out", OUT, cw);
            end else if (mode == 1) begin
                chk("rand.sgl_fix", OUT, cw);
                chk("rand.sgl_syn", 137'(SYN), 137'({1'b1, 8'(p)}));
            end else if (mode == 2) begin
                chk("rand.dbl_flag", 137'(DBL), 137'(1'b1));
                chk("rand.dbl_syn", 137'(SYN), 137'({1'b0, 8'(p ^ q)}));
                chk("rand.dbl_out", OUT, v);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
